// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex 7-segment scan driver.
// Each digit slot is an anti-ghosting blank period followed by a lit period.
module seg7_scan_driver #(
  parameter int unsigned ON_CYCLES    = 1000,
  parameter int unsigned BLANK_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        polarity,
  input  logic        lzb,
  output logic [6:0]  segments,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  logic [1:0]       state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      shadow, shadow_n;
  logic [6:0]       seg_r, seg_n;
  logic [3:0]       dig_r, dig_n;
  logic             fd_n;
  logic [3:0]       nibble;
  logic             lead_zero;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Next-state, slot timing and registered-output computation.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    shadow_n = shadow;
    fd_n     = 1'b0;

    if (!enable) begin
      state_n = S_IDLE;
      idx_n   = 2'd0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n  = S_BLANK;
          idx_n    = 2'd0;
          cnt_n    = '0;
          shadow_n = value;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = S_ON;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
            if (idx == 2'd3) begin
              shadow_n = value;
              fd_n     = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Glyph and blanking are derived from the upcoming slot so outputs align with state.
    case (idx_n)
      2'd0: begin nibble = shadow_n[3:0];   lead_zero = 1'b0;                           end
      2'd1: begin nibble = shadow_n[7:4];   lead_zero = lzb && (shadow_n[15:4] == 12'h0); end
      2'd2: begin nibble = shadow_n[11:8];  lead_zero = lzb && (shadow_n[15:8] == 8'h0);  end
      default: begin nibble = shadow_n[15:12]; lead_zero = lzb && (shadow_n[15:12] == 4'h0); end
    endcase

    seg_n = (state_n == S_ON && !lead_zero) ? glyph(nibble) : 7'h00;
    dig_n = (state_n == S_ON) ? (4'b0001 << idx_n) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      shadow     <= 16'h0000;
      seg_r      <= 7'h00;
      dig_r      <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      seg_r      <= seg_n;
      dig_r      <= dig_n;
      frame_done <= fd_n;
    end
  end

  // Polarity applied combinationally so a change is visible in the same cycle.
  assign segments = seg_r ^ {7{~polarity}};
  assign digit_en = dig_r ^ {4{~polarity}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with ON_CYCLES=4, BLANK_CYCLES=2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        polarity;
  logic        lzb;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_seg [4];

  seg7_scan_driver #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value),
    .polarity(polarity), .lzb(lzb), .segments(segments),
    .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then start scanning; returns positioned at frame cycle 1 (first BLANK cycle).
  task automatic start_frame(input logic [15:0] v);
    value  = v;
    enable = 1'b1;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    tick();
  endtask

  // From frame cycle 1, check the first ON cycle of each digit (cycles 3, 9, 15, 21).
  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e [4];
    logic [3:0] oh;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    tick(2);
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      check($sformatf("%s_dig%0d_en", tag, d), digit_en, oh);
      check($sformatf("%s_dig%0d_seg", tag, d), segments, e[d]);
      if (d < 3) tick(6);
    end
  endtask

  initial begin
    logic [3:0] oh;
    int slot, pos;
    exp_seg[0] = 7'h66; exp_seg[1] = 7'h77; exp_seg[2] = 7'h5B; exp_seg[3] = 7'h06;

    // Reset state
    reset = 1'b1; enable = 1'b0; value = 16'h12A4; polarity = 1'b1; lzb = 1'b0;
    tick(2);
    check("rst_dig", digit_en, 4'h0);
    check("rst_seg", segments, 7'h00);
    check("rst_fd", frame_done, 1'b0);
    polarity = 1'b0; #1;
    check("rst_pol0_seg", segments, 7'h7F);
    check("rst_pol0_dig", digit_en, 4'hF);
    polarity = 1'b1;
    enable = 1'b1;
    tick();
    check("rst_priority_dig", digit_en, 4'h0);

    // Basic frame 12A4, full cycle-by-cycle
    reset = 1'b0;
    tick();
    for (int c = 1; c <= 24; c++) begin
      slot = (c - 1) / 6;
      pos  = (c - 1) % 6;
      oh   = (pos < 2) ? 4'b0000 : (4'b0001 << slot);
      check($sformatf("frame_c%0d_dig", c), digit_en, oh);
      check($sformatf("frame_c%0d_seg", c), segments, (pos < 2) ? 7'h00 : exp_seg[slot]);
      check($sformatf("frame_c%0d_fd", c), frame_done, 1'b0);
      tick();
    end
    check("c25_fd", frame_done, 1'b1);
    check("c25_dig", digit_en, 4'h0);
    tick();
    check("c26_fd", frame_done, 1'b0);

    // Leading-zero blanking
    lzb = 1'b1;
    start_frame(16'h0007);
    check_digits("lzb0007", 7'h07, 7'h00, 7'h00, 7'h00);
    start_frame(16'h0000);
    check_digits("lzb0000", 7'h3F, 7'h00, 7'h00, 7'h00);
    start_frame(16'h0100);
    check_digits("lzb0100", 7'h3F, 7'h3F, 7'h06, 7'h00);

    // lzb sampled every cycle
    start_frame(16'h0007);
    tick(8);
    check("lzb_live_on", segments, 7'h00);
    lzb = 1'b0;
    tick();
    check("lzb_live_off", segments, 7'h3F);
    check("lzb_live_dig", digit_en, 4'b0010);

    // Active-low polarity
    polarity = 1'b0;
    start_frame(16'h0008);
    check("pol0_blank_dig", digit_en, 4'hF);
    check("pol0_blank_seg", segments, 7'h7F);
    tick(2);
    check("pol0_on_dig", digit_en, 4'b1110);
    check("pol0_on_seg", segments, 7'h00);
    polarity = 1'b1; #1;
    check("pol_comb_dig", digit_en, 4'b0001);
    check("pol_comb_seg", segments, 7'h7F);

    // No tearing: value change mid-frame
    start_frame(16'h1111);
    tick(8);
    check("tear_d1_dig", digit_en, 4'b0010);
    value = 16'h2222;
    check("tear_d1_seg", segments, 7'h06);
    tick(6);
    check("tear_d2_seg", segments, 7'h06);
    tick(6);
    check("tear_d3_seg", segments, 7'h06);
    tick(4);
    check("tear_fd", frame_done, 1'b1);
    check_digits("tear_next", 7'h5B, 7'h5B, 7'h5B, 7'h5B);

    // Enable dropped during digit 2 ON
    start_frame(16'h12A4);
    tick(14);
    check("en_d2_dig", digit_en, 4'b0100);
    check("en_d2_seg", segments, 7'h5B);
    enable = 1'b0;
    tick();
    check("en_off_dig", digit_en, 4'h0);
    check("en_off_seg", segments, 7'h00);
    check("en_off_fd", frame_done, 1'b0);
    tick(3);
    check("en_off_hold", digit_en, 4'h0);
    enable = 1'b1;
    tick();
    check("en_re_b1", digit_en, 4'h0);
    tick();
    check("en_re_b2", digit_en, 4'h0);
    tick();
    check("en_re_on_dig", digit_en, 4'b0001);
    check("en_re_on_seg", segments, 7'h66);

    // Reset during digit 3 ON
    start_frame(16'h12A4);
    tick(20);
    check("rst_d3_dig", digit_en, 4'b1000);
    reset = 1'b1;
    tick();
    check("rst_mid_dig", digit_en, 4'h0);
    check("rst_mid_seg", segments, 7'h00);
    check("rst_mid_fd", frame_done, 1'b0);
    reset = 1'b0;
    tick();
    for (int c = 1; c <= 24; c++) begin
      check($sformatf("rst_resume_c%0d_fd", c), frame_done, 1'b0);
      tick();
    end
    check("rst_resume_c25_fd", frame_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 1000: clocks each digit is lit per slot; legal range >=1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 24: anti-ghosting clocks with all digits off before each lit slot; legal range >=1.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: 1 means scanning runs; 0 means idle, all outputs inactive.
REQ-006 SHALL have port value, input, 16 bits: hex value to display; nibble n drives digit n (digit 0 = value[3:0]).
REQ-007 SHALL have port polarity, input, 1 bit: 0 means segments and digit enables are active-low; 1 means active-high.
REQ-008 SHALL have port lzb, input, 1 bit: 1 enables leading-zero blanking.
REQ-009 SHALL have port segments, output, 7 bits: shared segment lines, bit order g,f,e,d,c,b,a (bit 6..0).
REQ-010 SHALL have port digit_en, output, 4 bits: one-hot digit select; bit n drives digit n.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each completed 4-digit frame.

Function
REQ-012 SHALL keep raw registers seg_r[6:0] and dig_r[3:0] (1 = on). Outputs: segments = seg_r XOR {7{~polarity}}; digit_en = dig_r XOR {4{~polarity}}. Polarity SHALL be combinational, so a change takes effect in the same cycle.
REQ-013 SHALL implement states IDLE, BLANK and ON, plus a 2-bit digit index idx, a slot counter, and a 16-bit shadow register.
REQ-014 IDLE with enable=1: on the next edge SHALL go to BLANK, set idx=0, set counter=0 and load shadow<=value.
REQ-015 BLANK SHALL last exactly BLANK_CYCLES cycles with dig_r=0 and seg_r=0, then go to ON.
REQ-016 ON SHALL last exactly ON_CYCLES cycles with dig_r one-hot at idx and seg_r equal to the hex glyph of shadow nibble idx.
REQ-017 At the end of ON with idx<3: SHALL set idx+1 and go to BLANK.
REQ-018 At the end of ON with idx=3: SHALL wrap idx to 0, go to BLANK, reload shadow<=value, and assert frame_done for exactly that following cycle.
REQ-019 Frame length SHALL be 4*(BLANK_CYCLES+ON_CYCLES) cycles.
REQ-020 frame_done SHALL NOT pulse on the initial start from IDLE.
REQ-021 Hex glyphs SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-022 Changes to value mid-frame SHALL NOT affect the displayed digits until the next shadow reload (no tearing).
REQ-023 With lzb=1, digit n (n=1..3) SHALL have seg_r=0 in ON if shadow nibbles n..3 are all zero; dig_r SHALL still assert, so slot timing is unchanged.
REQ-024 Digit 0 SHALL never be blanked by lzb.
REQ-025 lzb SHALL be sampled every cycle.
REQ-026 enable=0 in any state: on the next edge SHALL go to IDLE, set dig_r=0, seg_r=0, frame_done=0 and idx=0; an in-progress frame is abandoned.
REQ-027 enable re-asserted SHALL restart per REQ-014.
REQ-028 The slot counter SHALL be sized to hold max(ON_CYCLES, BLANK_CYCLES)-1 and SHALL never overflow.
REQ-029 dig_r SHALL never have more than one bit set.
REQ-030 dig_r SHALL never be nonzero in the cycle immediately after a different nonzero dig_r; BLANK always separates lit slots.

Reset
REQ-031 reset=1 SHALL take priority over enable. On that edge: state=IDLE, idx=0, counter=0, shadow=0, seg_r=0, dig_r=0, frame_done=0.
REQ-032 With polarity=0, the reset output values SHALL be segments=7'h7F and digit_en=4'hF.
REQ-033 Reset asserted mid-frame SHALL give inactive outputs from the next cycle; scanning resumes per REQ-014 after release if enable=1.

Verification (ON_CYCLES=4, BLANK_CYCLES=2, polarity=1 unless stated)
REQ-034 value=16'h12A4, lzb=0, enable=1 after reset -> digit_en: 0000 x2, 0001 x4 with seg 66, 0000 x2, 0010 x4 with seg 77, 0000 x2, 0100 x4 with seg 5B, 0000 x2, 1000 x4 with seg 06; frame_done=1 on cycle 25 only.
REQ-035 lzb=1, value=16'h0007 -> digits 3,2,1 show seg 00 with digit_en asserted, digit 0 shows 07; value=16'h0000 -> digit 0 shows 3F; value=16'h0100 -> digits 2,1,0 show 06,3F,3F.
REQ-036 polarity=0, value=16'h0008 -> during digit 0 ON: digit_en=4'b1110, segments=7'b0000000; during BLANK: digit_en=4'hF, segments=7'h7F.
REQ-037 value changes 16'h1111->16'h2222 during digit 1 ON -> digits 1..3 still show 06 this frame; all digits show 5B from the next frame.
REQ-038 enable dropped during digit 2 ON -> next cycle digit_en=0000, segments=00; re-enable -> 2 BLANK cycles then digit 0 ON.
REQ-039 reset pulsed during digit 3 ON -> next cycle outputs inactive, frame_done stays 0.
